// File: rtl/mem_ctrl_arbiter_pkg.sv
// Shared types for the main-memory port arbiter: block address/data, request type,
// FSM state and transaction owner.
package mem_ctrl_arbiter_pkg;

    localparam int unsigned MAIN_MEM_BLOCK_ADDR_W = 26;
    localparam int unsigned BLOCK_DATA_W          = 128;
    localparam int unsigned MEM_ARB_MAX_IC_STREAK = 4;

    typedef logic [MAIN_MEM_BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
    typedef logic [BLOCK_DATA_W-1:0]          block_data_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_type_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } mem_arb_state_t;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } mem_arb_owner_t;

endpackage

// File: rtl/mem_ctrl_arbiter_if.sv
// Cache-side and memory-side handshake signals of the arbiter. The slave modport is the
// arbiter's view; master is the view of the caches and memory controller around it.
interface mem_ctrl_arbiter_if;
    import mem_ctrl_arbiter_pkg::*;

    logic                 ic_req_valid;
    logic                 ic_req_ready;
    main_mem_block_addr_t ic_req_block_addr;
    logic                 ic_resp_valid;
    block_data_t          ic_resp_block_data;

    logic                 dc_req_valid;
    logic                 dc_req_ready;
    req_type_t            dc_req_type;
    main_mem_block_addr_t dc_req_block_addr;
    block_data_t          dc_req_block_data;
    logic                 dc_resp_valid;
    block_data_t          dc_resp_block_data;

    logic                 mem_req_valid;
    logic                 mem_req_ready;
    req_type_t            mem_req_type;
    main_mem_block_addr_t mem_req_block_addr;
    block_data_t          mem_req_block_data;
    logic                 mem_resp_valid;
    block_data_t          mem_resp_block_data;

    modport slave (
        input  ic_req_valid, ic_req_block_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_block_data,
        input  dc_req_valid, dc_req_type, dc_req_block_addr, dc_req_block_data,
        output dc_req_ready, dc_resp_valid, dc_resp_block_data,
        output mem_req_valid, mem_req_type, mem_req_block_addr, mem_req_block_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_block_data
    );

    modport master (
        output ic_req_valid, ic_req_block_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_block_data,
        output dc_req_valid, dc_req_type, dc_req_block_addr, dc_req_block_data,
        input  dc_req_ready, dc_resp_valid, dc_resp_block_data,
        input  mem_req_valid, mem_req_type, mem_req_block_addr, mem_req_block_data,
        output mem_req_ready, mem_resp_valid, mem_resp_block_data
    );

endinterface

// File: rtl/mem_arb_streak_ctr.sv
// Saturating counter of consecutive contended icache grants; clear wins over increment.
module mem_arb_streak_ctr #(
    parameter int unsigned MaxCount = 4,
    localparam int unsigned Width   = $clog2(MaxCount + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != Width'(MaxCount))) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_ctrl_arbiter.sv
// Arbitrates the single main-memory port between icache and dcache miss paths, one
// transaction outstanding, icache priority with a bounded dcache starvation guard.
module mem_ctrl_arbiter
    import mem_ctrl_arbiter_pkg::*;
#(
    parameter int unsigned MAX_IC_STREAK = MEM_ARB_MAX_IC_STREAK
) (
    input  logic                clk,
    input  logic                rst,
    mem_ctrl_arbiter_if.slave   bus,
    output logic                busy
);

    localparam int unsigned StreakW = $clog2(MAX_IC_STREAK + 1);

    mem_arb_state_t       state_q;
    mem_arb_owner_t       owner_q;
    req_type_t            type_q;
    main_mem_block_addr_t addr_q;
    block_data_t          data_q;
    logic                 mem_req_valid_q;
    logic                 busy_q;

    logic [StreakW-1:0]   streak;
    logic                 idle, force_dc, ic_grant, dc_grant, in_wait;

    assign idle     = (state_q == IDLE);
    assign in_wait  = (state_q == WAIT_RESP);
    assign force_dc = bus.dc_req_valid && (streak == StreakW'(MAX_IC_STREAK));

    assign bus.ic_req_ready = idle && !force_dc;
    assign bus.dc_req_ready = idle && (!bus.ic_req_valid || force_dc);
    assign ic_grant         = bus.ic_req_valid && bus.ic_req_ready;
    assign dc_grant         = bus.dc_req_valid && bus.dc_req_ready;

    mem_arb_streak_ctr #(
        .MaxCount (MAX_IC_STREAK)
    ) u_streak (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (ic_grant && bus.dc_req_valid),
        .clr_i   (dc_grant || (ic_grant && !bus.dc_req_valid)),
        .count_o (streak)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_q         <= OWNER_IC;
            type_q          <= READ;
            addr_q          <= '0;
            data_q          <= '0;
            mem_req_valid_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ic_grant) begin
                        owner_q         <= OWNER_IC;
                        type_q          <= READ;
                        addr_q          <= bus.ic_req_block_addr;
                        data_q          <= '0;
                        state_q         <= ISSUE;
                        mem_req_valid_q <= 1'b1;
                        busy_q          <= 1'b1;
                    end else if (dc_grant) begin
                        owner_q         <= OWNER_DC;
                        type_q          <= bus.dc_req_type;
                        addr_q          <= bus.dc_req_block_addr;
                        data_q          <= bus.dc_req_block_data;
                        state_q         <= ISSUE;
                        mem_req_valid_q <= 1'b1;
                        busy_q          <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        // Writebacks complete at the handshake; only reads wait for data.
                        if (type_q == READ) begin
                            state_q <= WAIT_RESP;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (bus.mem_resp_valid) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q         <= IDLE;
                    mem_req_valid_q <= 1'b0;
                    busy_q          <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req_valid      = mem_req_valid_q;
    assign bus.mem_req_type       = type_q;
    assign bus.mem_req_block_addr = addr_q;
    assign bus.mem_req_block_data = data_q;

    assign bus.ic_resp_valid      = in_wait && bus.mem_resp_valid && (owner_q == OWNER_IC);
    assign bus.dc_resp_valid      = in_wait && bus.mem_resp_valid && (owner_q == OWNER_DC);
    assign bus.ic_resp_block_data = bus.mem_resp_block_data;
    assign bus.dc_resp_block_data = bus.mem_resp_block_data;

    assign busy = busy_q;

endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// Self-checking bench for mem_ctrl_arbiter: scenario tasks with request/response
// scoreboard queues filled as stimulus is driven and drained as the DUT responds.
module tb_mem_ctrl_arbiter;
    import mem_ctrl_arbiter_pkg::*;

    typedef struct {
        mem_arb_owner_t       owner;
        req_type_t            typ;
        main_mem_block_addr_t addr;
        block_data_t          data;
    } req_t;

    typedef struct {
        mem_arb_owner_t owner;
        block_data_t    data;
    } resp_t;

    logic clk;
    logic rst;
    logic busy;
    int   vectors;
    int   miscompares;
    req_t  req_q[$];
    resp_t resp_q[$];

    mem_ctrl_arbiter_if bus ();

    mem_ctrl_arbiter #(
        .MAX_IC_STREAK (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    function automatic block_data_t mem_data(main_mem_block_addr_t a);
        return {4{6'h2A, a}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_quiet();
        bus.ic_req_valid        = 1'b0;
        bus.ic_req_block_addr   = '0;
        bus.dc_req_valid        = 1'b0;
        bus.dc_req_type         = READ;
        bus.dc_req_block_addr   = '0;
        bus.dc_req_block_data   = '0;
        bus.mem_req_ready       = 1'b0;
        bus.mem_resp_valid      = 1'b0;
        bus.mem_resp_block_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_quiet();
        tick();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, bus.mem_req_valid, bus.ic_resp_valid, bus.dc_resp_valid} !== 4'b0000) begin
            $display("FAIL reset_outputs: got %b, required 0000",
                     {busy, bus.mem_req_valid, bus.ic_resp_valid, bus.dc_resp_valid});
            miscompares++;
        end
        vectors++;
        if ({bus.mem_req_type, bus.mem_req_block_addr, bus.mem_req_block_data} !== '0) begin
            $display("FAIL reset_latched: got addr %h data %h, required 0",
                     bus.mem_req_block_addr, bus.mem_req_block_data);
            miscompares++;
        end
        vectors++;
        if ({bus.ic_req_ready, bus.dc_req_ready} !== 2'b11) begin
            $display("FAIL reset_readies: got %b, required 11",
                     {bus.ic_req_ready, bus.dc_req_ready});
            miscompares++;
        end
        vectors++;
        if (int'(dut.streak) !== 0) begin
            $display("FAIL reset_streak: got %0d, required 0", dut.streak);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_ic_read();
        req_t  er;
        resp_t es;
        bus.ic_req_valid      = 1'b1;
        bus.ic_req_block_addr = 26'h40;
        req_q.push_back('{OWNER_IC, READ, 26'h40, '0});
        @(negedge clk);
        vectors++;
        if ({bus.ic_req_ready, bus.dc_req_ready} !== 2'b10) begin
            $display("FAIL ic_grant: got %b, required 10", {bus.ic_req_ready, bus.dc_req_ready});
            miscompares++;
        end
        tick();
        bus.ic_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        er = req_q.pop_front();
        vectors++;
        if ({bus.mem_req_valid, bus.mem_req_type, bus.mem_req_block_addr} !==
            {1'b1, er.typ, er.addr}) begin
            $display("FAIL ic_mem_req: got v=%b t=%0d a=%h, required v=1 t=%0d a=%h",
                     bus.mem_req_valid, bus.mem_req_type, bus.mem_req_block_addr,
                     er.typ, er.addr);
            miscompares++;
        end
        resp_q.push_back('{OWNER_IC, mem_data(er.addr)});
        tick();
        bus.mem_req_ready = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            vectors++;
            if ({bus.mem_req_valid, busy, bus.ic_resp_valid, bus.dc_resp_valid} !== 4'b0100) begin
                $display("FAIL ic_wait_c%0d: got %b, required 0100", c,
                         {bus.mem_req_valid, busy, bus.ic_resp_valid, bus.dc_resp_valid});
                miscompares++;
            end
            tick();
        end
        es = resp_q.pop_front();
        bus.mem_resp_valid      = 1'b1;
        bus.mem_resp_block_data = es.data;
        @(negedge clk);
        vectors++;
        if ({bus.ic_resp_valid, bus.dc_resp_valid, bus.ic_resp_block_data} !==
            {2'b10, es.data}) begin
            $display("FAIL ic_resp: got v=%b d=%h, required v=10 d=%h",
                     {bus.ic_resp_valid, bus.dc_resp_valid}, bus.ic_resp_block_data, es.data);
            miscompares++;
        end
        tick();
        bus.mem_resp_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL ic_done_busy: got %b, required 0", busy);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_streak();
        mem_arb_owner_t exp_owner[6] = '{OWNER_IC, OWNER_IC, OWNER_IC, OWNER_IC,
                                         OWNER_DC, OWNER_IC};
        int             exp_pre[6]   = '{0, 1, 2, 3, 4, 0};
        int             exp_post[6]  = '{1, 2, 3, 4, 0, 1};
        req_t           er;
        resp_t          es;
        bus.dc_req_valid      = 1'b1;
        bus.dc_req_type       = READ;
        bus.dc_req_block_addr = 26'h200;
        for (int g = 0; g < 6; g++) begin
            bus.ic_req_valid      = 1'b1;
            bus.ic_req_block_addr = 26'h100 + 26'(g);
            if (exp_owner[g] == OWNER_IC)
                req_q.push_back('{OWNER_IC, READ, 26'h100 + 26'(g), '0});
            else
                req_q.push_back('{OWNER_DC, READ, 26'h200, '0});
            @(negedge clk);
            vectors++;
            if (int'(dut.streak) !== exp_pre[g]) begin
                $display("FAIL streak_pre_g%0d: got %0d, required %0d", g, dut.streak, exp_pre[g]);
                miscompares++;
            end
            vectors++;
            if ({bus.ic_req_valid && bus.ic_req_ready, bus.dc_req_valid && bus.dc_req_ready} !==
                ((exp_owner[g] == OWNER_IC) ? 2'b10 : 2'b01)) begin
                $display("FAIL streak_grant_g%0d: got %b, required owner %0d", g,
                         {bus.ic_req_ready, bus.dc_req_ready}, exp_owner[g]);
                miscompares++;
            end
            tick();
            bus.mem_req_ready = 1'b1;
            @(negedge clk);
            er = req_q.pop_front();
            vectors++;
            if ({bus.mem_req_valid, bus.mem_req_block_addr} !== {1'b1, er.addr}) begin
                $display("FAIL streak_req_g%0d: got v=%b a=%h, required v=1 a=%h", g,
                         bus.mem_req_valid, bus.mem_req_block_addr, er.addr);
                miscompares++;
            end
            vectors++;
            if (int'(dut.streak) !== exp_post[g]) begin
                $display("FAIL streak_post_g%0d: got %0d, required %0d", g, dut.streak,
                         exp_post[g]);
                miscompares++;
            end
            resp_q.push_back('{er.owner, mem_data(er.addr)});
            tick();
            bus.mem_req_ready = 1'b0;
            es = resp_q.pop_front();
            bus.mem_resp_valid      = 1'b1;
            bus.mem_resp_block_data = es.data;
            @(negedge clk);
            vectors++;
            if ({bus.ic_resp_valid, bus.dc_resp_valid, bus.dc_resp_block_data} !==
                {((es.owner == OWNER_IC) ? 2'b10 : 2'b01), es.data}) begin
                $display("FAIL streak_resp_g%0d: got v=%b d=%h, required owner %0d d=%h", g,
                         {bus.ic_resp_valid, bus.dc_resp_valid}, bus.dc_resp_block_data,
                         es.owner, es.data);
                miscompares++;
            end
            tick();
            bus.mem_resp_valid = 1'b0;
        end
        drive_quiet();
        tick();
    endtask

    task automatic test_dc_write();
        req_t        er;
        block_data_t wd = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF;
        bus.dc_req_valid      = 1'b1;
        bus.dc_req_type       = WRITE;
        bus.dc_req_block_addr = 26'h80;
        bus.dc_req_block_data = wd;
        req_q.push_back('{OWNER_DC, WRITE, 26'h80, wd});
        @(negedge clk);
        vectors++;
        if (bus.dc_req_ready !== 1'b1) begin
            $display("FAIL wr_grant: got %b, required 1", bus.dc_req_ready);
            miscompares++;
        end
        tick();
        drive_quiet();
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        er = req_q.pop_front();
        vectors++;
        if ({bus.mem_req_valid, bus.mem_req_type, bus.mem_req_block_addr,
             bus.mem_req_block_data} !== {1'b1, er.typ, er.addr, er.data}) begin
            $display("FAIL wr_req: got v=%b t=%0d a=%h d=%h, required v=1 t=%0d a=%h d=%h",
                     bus.mem_req_valid, bus.mem_req_type, bus.mem_req_block_addr,
                     bus.mem_req_block_data, er.typ, er.addr, er.data);
            miscompares++;
        end
        tick();
        bus.mem_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({busy, bus.mem_req_valid, bus.dc_resp_valid} !== 3'b000) begin
                $display("FAIL wr_after_c%0d: got %b, required 000", c,
                         {busy, bus.mem_req_valid, bus.dc_resp_valid});
                miscompares++;
            end
            tick();
        end
    endtask

    task automatic test_stall();
        req_t        er;
        block_data_t wd = 128'h0F0F_1234_5678_9ABC_DEF0_0F0F_A5A5_5A5A;
        bus.dc_req_valid      = 1'b1;
        bus.dc_req_type       = WRITE;
        bus.dc_req_block_addr = 26'hC0;
        bus.dc_req_block_data = wd;
        req_q.push_back('{OWNER_DC, WRITE, 26'hC0, wd});
        @(negedge clk);
        vectors++;
        if (bus.dc_req_ready !== 1'b1) begin
            $display("FAIL stall_grant: got %b, required 1", bus.dc_req_ready);
            miscompares++;
        end
        tick();
        // Both caches keep requesting while memory back-pressures.
        bus.ic_req_valid      = 1'b1;
        bus.ic_req_block_addr = 26'h1C0;
        bus.dc_req_block_addr = 26'h2C0;
        bus.dc_req_block_data = ~wd;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if ({bus.mem_req_valid, bus.mem_req_type, bus.mem_req_block_addr,
                 bus.mem_req_block_data} !== {1'b1, req_q[0].typ, req_q[0].addr, req_q[0].data}) begin
                $display("FAIL stall_hold_c%0d: got v=%b a=%h d=%h, required v=1 a=%h d=%h", c,
                         bus.mem_req_valid, bus.mem_req_block_addr, bus.mem_req_block_data,
                         req_q[0].addr, req_q[0].data);
                miscompares++;
            end
            vectors++;
            if ({bus.ic_req_ready, bus.dc_req_ready, busy} !== 3'b001) begin
                $display("FAIL stall_nogrant_c%0d: got %b, required 001", c,
                         {bus.ic_req_ready, bus.dc_req_ready, busy});
                miscompares++;
            end
            tick();
        end
        drive_quiet();
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        er = req_q.pop_front();
        vectors++;
        if ({bus.mem_req_valid, bus.mem_req_block_addr} !== {1'b1, er.addr}) begin
            $display("FAIL stall_release: got v=%b a=%h, required v=1 a=%h",
                     bus.mem_req_valid, bus.mem_req_block_addr, er.addr);
            miscompares++;
        end
        tick();
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL stall_done_busy: got %b, required 0", busy);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_spurious();
        req_t  er;
        resp_t es;
        bus.mem_resp_valid      = 1'b1;
        bus.mem_resp_block_data = 128'h5555;
        @(negedge clk);
        vectors++;
        if ({bus.ic_resp_valid, bus.dc_resp_valid} !== 2'b00) begin
            $display("FAIL spur_idle: got %b, required 00", {bus.ic_resp_valid, bus.dc_resp_valid});
            miscompares++;
        end
        tick();
        bus.ic_req_valid      = 1'b1;
        bus.ic_req_block_addr = 26'h240;
        req_q.push_back('{OWNER_IC, READ, 26'h240, '0});
        @(negedge clk);
        vectors++;
        if ({bus.ic_req_ready, bus.ic_resp_valid, bus.dc_resp_valid} !== 3'b100) begin
            $display("FAIL spur_grant: got %b, required 100",
                     {bus.ic_req_ready, bus.ic_resp_valid, bus.dc_resp_valid});
            miscompares++;
        end
        tick();
        bus.ic_req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            bus.mem_req_ready = (c == 2);
            @(negedge clk);
            vectors++;
            if ({bus.mem_req_valid, bus.ic_resp_valid, bus.dc_resp_valid} !== 3'b100) begin
                $display("FAIL spur_issue_c%0d: got %b, required 100", c,
                         {bus.mem_req_valid, bus.ic_resp_valid, bus.dc_resp_valid});
                miscompares++;
            end
            if (c == 2) begin
                er = req_q.pop_front();
                resp_q.push_back('{OWNER_IC, mem_data(er.addr)});
            end
            tick();
        end
        drive_quiet();
        @(negedge clk);
        vectors++;
        if ({busy, bus.ic_resp_valid} !== 2'b10) begin
            $display("FAIL spur_wait: got %b, required 10", {busy, bus.ic_resp_valid});
            miscompares++;
        end
        tick();
        es = resp_q.pop_front();
        bus.mem_resp_valid      = 1'b1;
        bus.mem_resp_block_data = es.data;
        @(negedge clk);
        vectors++;
        if ({bus.ic_resp_valid, bus.dc_resp_valid, bus.ic_resp_block_data} !==
            {2'b10, es.data}) begin
            $display("FAIL spur_real_resp: got v=%b d=%h, required v=10 d=%h",
                     {bus.ic_resp_valid, bus.dc_resp_valid}, bus.ic_resp_block_data, es.data);
            miscompares++;
        end
        tick();
        drive_quiet();
        tick();
    endtask

    task automatic test_reset_mid();
        req_t er;
        bus.ic_req_valid      = 1'b1;
        bus.ic_req_block_addr = 26'h300;
        bus.dc_req_valid      = 1'b1;
        bus.dc_req_type       = READ;
        bus.dc_req_block_addr = 26'h380;
        req_q.push_back('{OWNER_IC, READ, 26'h300, '0});
        tick();
        drive_quiet();
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        er = req_q.pop_front();
        vectors++;
        if ({bus.mem_req_valid, bus.mem_req_block_addr, int'(dut.streak)} !==
            {1'b1, er.addr, 1}) begin
            $display("FAIL rmid_req: got v=%b a=%h s=%0d, required v=1 a=%h s=1",
                     bus.mem_req_valid, bus.mem_req_block_addr, dut.streak, er.addr);
            miscompares++;
        end
        tick();
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus.mem_resp_valid      = 1'b1;
        bus.mem_resp_block_data = mem_data(26'h300);
        bus.ic_req_valid        = 1'b1;
        bus.ic_req_block_addr   = 26'h340;
        req_q.push_back('{OWNER_IC, READ, 26'h340, '0});
        @(negedge clk);
        vectors++;
        if ({bus.ic_resp_valid, bus.dc_resp_valid, busy, bus.ic_req_ready} !== 4'b0001) begin
            $display("FAIL rmid_drop: got %b, required 0001",
                     {bus.ic_resp_valid, bus.dc_resp_valid, busy, bus.ic_req_ready});
            miscompares++;
        end
        vectors++;
        if (int'(dut.streak) !== 0) begin
            $display("FAIL rmid_streak: got %0d, required 0", dut.streak);
            miscompares++;
        end
        tick();
        drive_quiet();
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        er = req_q.pop_front();
        vectors++;
        if ({bus.mem_req_valid, bus.mem_req_block_addr} !== {1'b1, er.addr}) begin
            $display("FAIL rmid_new_req: got v=%b a=%h, required v=1 a=%h",
                     bus.mem_req_valid, bus.mem_req_block_addr, er.addr);
            miscompares++;
        end
        tick();
        drive_quiet();
        bus.mem_resp_valid      = 1'b1;
        bus.mem_resp_block_data = mem_data(er.addr);
        @(negedge clk);
        vectors++;
        if ({bus.ic_resp_valid, bus.ic_resp_block_data} !== {1'b1, mem_data(er.addr)}) begin
            $display("FAIL rmid_new_resp: got v=%b d=%h, required v=1 d=%h",
                     bus.ic_resp_valid, bus.ic_resp_block_data, mem_data(er.addr));
            miscompares++;
        end
        tick();
        drive_quiet();
        vectors++;
        if (req_q.size() + resp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d entries left, required 0",
                     req_q.size() + resp_q.size());
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        drive_quiet();
        test_reset();
        test_ic_read();
        test_streak();
        test_dc_write();
        test_stall();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_arbiter.md
# mem_ctrl_arbiter

Shares the single main-memory controller port between the instruction-cache and data-cache miss paths. Each cache's memory-request and response interfaces connect here, and one request/response channel goes out to the main-memory controller. Only one transaction is outstanding at a time. Icache has priority, with a bounded-starvation guard for dcache. Read responses are routed back to the requester that owns the transaction.

## Interface
Parameters:
- MAX_IC_STREAK, default 4: number of consecutive contended icache grants allowed before dcache is forced a grant. Must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- ic_req_valid  in  1  icache miss request
- ic_req_ready  out  1  icache request accepted (grant)
- ic_req_block_addr  in  main_mem_block_addr_t  icache miss block address
- ic_resp_valid  out  1  icache fill data valid
- ic_resp_block_data  out  block_data_t  icache fill data
- dc_req_valid  in  1  dcache request (fill or writeback)
- dc_req_ready  out  1  dcache request accepted (grant)
- dc_req_type  in  req_type_t  READ (fill) or WRITE (writeback)
- dc_req_block_addr  in  main_mem_block_addr_t  dcache block address
- dc_req_block_data  in  block_data_t  writeback data; ignored for READ
- dc_resp_valid  out  1  dcache fill data valid
- dc_resp_block_data  out  block_data_t  dcache fill data
- mem_req_valid  out  1  request to the main-memory controller
- mem_req_ready  in  1  main-memory controller accepts the request
- mem_req_type  out  req_type_t  READ/WRITE
- mem_req_block_addr  out  main_mem_block_addr_t  latched block address
- mem_req_block_data  out  block_data_t  latched writeback data
- mem_resp_valid  in  1  read data return, valid for one cycle
- mem_resp_block_data  in  block_data_t  read data
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP. Registers: owner (IC/DC), type, addr, data, and the streak counter.
- Grant in IDLE (combinational readies):
  - force_dc = dc_req_valid && streak==MAX_IC_STREAK.
  - ic_req_ready = IDLE && !force_dc.
  - dc_req_ready = IDLE && (!ic_req_valid || force_dc).
  - ic_req_ready and dc_req_ready are never both granted in the same cycle.
- Streak counter update on a grant:
  - IC grant while dc_req_valid: streak+1.
  - IC grant with no dcache contention: streak=0.
  - Any DC grant: streak=0.
  - The counter saturates at MAX_IC_STREAK.
- Icache requests are always type READ.
- On any grant, latch owner/type/addr/data and go to ISSUE.
- ISSUE: mem_req_valid=1, driven from the latched registers and held stable until mem_req_ready.
  - On handshake with READ: go to WAIT_RESP.
  - On handshake with WRITE: go to IDLE. Writebacks have no response; the dcache treats the handshake as complete.
- WAIT_RESP: on mem_resp_valid, the owner's resp_valid=1 in the same cycle (combinational pass-through). Then go to IDLE.
- mem_resp_block_data fans out to both *_resp_block_data unconditionally. Only the owner's resp_valid qualifies it.
- mem_resp_valid outside WAIT_RESP is ignored and produces no resp_valid.
- Fetch redirects and cache flushes do not abort a transaction. The icache discards stale fills itself.

## Timing
- Reset values (next edge with rst=1):
  - state=IDLE, streak=0, owner=IC, latched addr/data/type=0.
  - All valid/ready outputs and busy deassert in that cycle's registered state.
  - The readies follow their IDLE equations immediately after reset.
- Reset mid-transaction: the FSM returns to IDLE and any later mem_resp_valid is dropped. The memory controller is reset on the same rst.
- Grant to memory request: grant in cycle N gives mem_req_valid in cycle N+1. With mem_req_ready=1 at N+1 it is accepted at N+1.
- Response routing: mem_resp_valid in cycle M gives owner resp_valid in cycle M. A new grant is possible at M+1.
- Minimum back-to-back spacing:
  - READ: 3 cycles plus memory latency.
  - WRITE: 2 cycles (IDLE grant, ISSUE).
- Requesters hold valid and request fields stable until ready. The arbiter samples them only on the grant cycle.
- mem_req_ready low in ISSUE: stall indefinitely in ISSUE; outputs are unchanged.

## Structure
- The global package holds:
  - mem_arb_state_t {IDLE, ISSUE, WAIT_RESP}
  - mem_arb_owner_t {OWNER_IC, OWNER_DC}
  - MEM_ARB_MAX_IC_STREAK default constant
- Reused from the existing package: main_mem_block_addr_t, block_data_t, req_type_t.
- Sub-module: mem_arb_streak_ctr. It is a saturating counter of width $clog2(MAX_IC_STREAK+1), with inc, clr and sync-rst inputs.

## Test plan
- Icache only, READ addr 0x40, memory latency 5:
  - ic_req_ready in cycle 0 and mem_req_valid in cycle 1 with addr 0x40.
  - mem_resp_valid in cycle 6 drives ic_resp_valid in cycle 6 with data matching; dc_resp_valid stays 0.
- Simultaneous ic and dc requests, both held, MAX_IC_STREAK=4:
  - Grants go IC, IC, IC, IC, DC, then IC.
  - Streak reads 4 before the DC grant and 0 after it.
- dc WRITE addr 0x80 with data 0xDEAD…:
  - mem_req_type=WRITE with data latched.
  - After the handshake, back in IDLE the next cycle; no dc_resp_valid is ever produced.
- mem_req_ready held low for 10 cycles in ISSUE:
  - mem_req_valid and addr/data stay stable for all 10 cycles.
  - No grants are issued (both readies 0, busy=1).
- Spurious mem_resp_valid in IDLE or ISSUE: no ic_resp_valid or dc_resp_valid pulse.
- rst asserted in WAIT_RESP, then mem_resp_valid 2 cycles later:
  - The response is dropped; the FSM is in IDLE with streak=0.
  - A new icache request is granted immediately.
